// File: rtl/nms_window_scheduler.sv
// Raster-order 3x3 window builder for the NMS corner checker: two line buffers,
// border masking, 2-cycle coordinate tagging and a small corner-coordinate FIFO.
module nms_window_scheduler #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 48,
  parameter int DATA_W     = 32,
  parameter int COORD_W    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_data,
  input  logic                  is_corner,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [COORD_W-1:0]    m_x,
  output logic [COORD_W-1:0]    m_y,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   col_q;
  logic [RW-1:0]                   row_q;
  logic [DATA_W-1:0]               lb0_q [IMG_W];
  logic [DATA_W-1:0]               lb1_q [IMG_W];
  logic [2:0][2:0][DATA_W-1:0]     win_q;       // [column][row], column 2 newest
  logic [1:0]                      vld_pipe_q;  // [0] window out, [1] checker result due
  logic [1:0][COORD_W-1:0]         cx_pipe_q, cy_pipe_q;
  logic [2*COORD_W-1:0]            fifo_q [FIFO_DEPTH];
  logic [AW-1:0]                   rd_ptr_q, wr_ptr_q;
  logic [AW:0]                     count_q;

  logic accept, issue, last_col, last_px, push, pop;
  logic [COORD_W-1:0] cx_now, cy_now;

  // Two slots of headroom cover the results still in the window/checker pipe.
  assign s_ready  = !reset && (state_q == RUN) && (count_q <= (AW+1)'(FIFO_DEPTH-3));
  assign accept   = s_valid && s_ready;
  assign last_col = (col_q == CW'(IMG_W-1));
  assign last_px  = last_col && (row_q == RW'(IMG_H-1));
  assign issue    = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign cx_now   = COORD_W'(col_q) - COORD_W'(1);
  assign cy_now   = COORD_W'(row_q) - COORD_W'(1);

  assign win_valid = vld_pipe_q[0];
  assign push      = vld_pipe_q[1] && is_corner;
  assign m_valid   = (count_q != '0);
  assign pop       = m_valid && m_ready;
  assign {m_y, m_x} = fifo_q[rd_ptr_q];

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign win_data[(3*r+c)*DATA_W +: DATA_W] = win_q[c][r];
    end
  end

  // Storage arrays carry no reset; stale contents are masked by row/col rules.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= s_data;
    end
    if (push) fifo_q[wr_ptr_q] <= {cy_pipe_q[1], cx_pipe_q[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      vld_pipe_q <= '0;
      cx_pipe_q  <= '0;
      cy_pipe_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= {vld_pipe_q[0], issue};
      cx_pipe_q  <= {cx_pipe_q[0], cx_now};
      cy_pipe_q  <= {cy_pipe_q[0], cy_now};
      if (accept) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= {s_data, lb1_q[col_q], lb0_q[col_q]};
        if (last_col) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      RUN:   if (accept && last_px) state_d = FLUSH;
      FLUSH: if ((vld_pipe_q == '0) && (count_q == '0)) state_d = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end
endmodule

// File: tb/tb_nms_window_scheduler.sv
// Randomized bench for nms_window_scheduler against a frame-level reference model
// (expected windows and corners derived directly from the image array).
module tb_nms_window_scheduler;
  localparam int W  = 6;
  localparam int H  = 5;
  localparam int DW = 32;
  localparam int CWD = 16;
  localparam int FD = 4;
  localparam int NWIN = (W-2)*(H-2);

  typedef struct packed { int f; int x; int y; logic [8:0][DW-1:0] w; } win_t;
  typedef struct packed { int f; int x; int y; } cor_t;

  logic clk = 0, reset;
  logic s_valid, s_ready, win_valid, is_corner, m_valid, m_ready, frame_done;
  logic [DW-1:0] s_data;
  logic [9*DW-1:0] win_data;
  logic [CWD-1:0] m_x, m_y;

  nms_window_scheduler #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .COORD_W(CWD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .win_valid(win_valid), .win_data(win_data), .is_corner(is_corner),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .frame_done(frame_done));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cur_frame = 0, done_frame = 0, fd_cnt = 0, win_cnt = 0, cor_cnt = 0;
  bit ck_mode = 0;  // 0: strict max and >1, 1: every window is a corner
  int mr_mode = 0;  // 0: m_ready high, 1: random, 2: held low
  logic fd_prev = 0;
  logic [DW-1:0] img [W*H];
  logic [DW-1:0] pix_q [$];
  win_t exp_win [$];
  cor_t exp_cor [$];

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit strict_max(input logic [8:0][DW-1:0] w);
    bit r = (w[4] > 1);
    for (int k = 0; k < 9; k++) if (k != 4 && w[k] >= w[4]) r = 0;
    return r;
  endfunction

  // Checker model: registered decision one cycle after the window.
  always @(posedge clk)
    if (reset) is_corner <= 1'b0;
    else is_corner <= win_valid && (ck_mode || strict_max(win_data));

  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    win_t e;
    cor_t c;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (win_valid) begin
          win_cnt++;
          if (exp_win.size() == 0) chk("win_extra", 1, 0);
          else begin
            e = exp_win.pop_front();
            chk($sformatf("win(%0d,%0d)", e.x, e.y), win_data, e.w);
          end
        end
        if (m_valid && m_ready) begin
          cor_cnt++;
          if (exp_cor.size() == 0) chk("cor_extra", 1, 0);
          else begin
            c = exp_cor.pop_front();
            chk("m_x", m_x, c.x);
            chk("m_y", m_y, c.y);
          end
        end
        if (frame_done) begin
          chk("fd_pulse_len", fd_prev, 0);
          chk("fd_win_left", (exp_win.size() != 0 && exp_win[0].f == done_frame), 0);
          chk("fd_cor_left", (exp_cor.size() != 0 && exp_cor[0].f == done_frame), 0);
          done_frame++;
          fd_cnt++;
        end
      end
      fd_prev = frame_done;
    end
  end

  task automatic fill(input int maxv);
    for (int i = 0; i < W*H; i++) img[i] = (maxv == 0) ? '0 : DW'($urandom_range(0, maxv));
  endtask

  task automatic prepare_frame();
    win_t e;
    cor_t c;
    for (int i = 0; i < W*H; i++) pix_q.push_back(img[i]);
    for (int y = 1; y < H-1; y++)
      for (int x = 1; x < W-1; x++) begin
        e.f = cur_frame; e.x = x; e.y = y;
        for (int r = 0; r < 3; r++)
          for (int cc = 0; cc < 3; cc++) e.w[3*r+cc] = img[(y-1+r)*W + x-1+cc];
        exp_win.push_back(e);
        if (ck_mode || strict_max(e.w)) begin
          c.f = cur_frame; c.x = x; c.y = y;
          exp_cor.push_back(c);
        end
      end
    cur_frame++;
  endtask

  // Expects to start at posedge+1; returns at posedge+1.
  task automatic drive(input bit rnd, input int n);
    int sent = 0, guard = 0;
    while (sent < n && guard < 5000) begin
      s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_data  = pix_q[0];
      @(negedge clk);
      if (s_valid && s_ready) begin
        void'(pix_q.pop_front());
        sent++;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 0;
    chk("drive_timeout", sent, n);
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (fd_cnt < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_done_timeout", fd_cnt, n);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, c0;
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, c0;
    reset = 1; s_valid = 0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // Single interior peak.
    w0 = win_cnt; c0 = cor_cnt;
    fill(0); img[2*W+2] = 100;
    prepare_frame(); drive(0, W*H); wait_frames(1);
    chk("t1_windows", win_cnt - w0, NWIN);
    chk("t1_corners", cor_cnt - c0, 1);

    // Peaks only on the border: never a window centre.
    w0 = win_cnt; c0 = cor_cnt;
    fill(0); img[3*W+0] = 500; img[(H-1)*W + W-1] = 500;
    prepare_frame(); drive(0, W*H); wait_frames(2);
    chk("t2_windows", win_cnt - w0, NWIN);
    chk("t2_corners", cor_cnt - c0, 0);

    // Every window a corner with the sink stalled: backpressure must engage.
    ck_mode = 1; c0 = cor_cnt;
    fill(1000); prepare_frame();
    mr_mode = 2; @(posedge clk); #1;
    fork
      drive(0, W*H);
      begin
        repeat (40) @(negedge clk);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_stalled", pix_q.size() > 0, 1);
        mr_mode = 0;
      end
    join
    wait_frames(3);
    chk("t3_corners", cor_cnt - c0, NWIN);
    ck_mode = 0;

    // Random data, random source and sink handshakes.
    mr_mode = 1;
    for (int f = 0; f < 4; f++) begin
      fill(15); prepare_frame(); drive(1, W*H); wait_frames(4 + f);
    end

    // Reset mid row 3 while a corner sits in the FIFO.
    mr_mode = 2;
    fill(0); img[1*W+1] = 77;
    prepare_frame(); drive(0, 3*W+2);
    @(negedge clk);
    chk("pre_rst_fifo", m_valid, 1);
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    chk("mid_rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    pix_q.delete(); exp_win.delete(); exp_cor.delete();
    done_frame = cur_frame;
    @(posedge clk); #1; reset = 0; mr_mode = 1;
    w0 = win_cnt;
    fill(15); prepare_frame(); drive(1, W*H); wait_frames(fd_cnt + 1);
    chk("t5_windows", win_cnt - w0, NWIN);

    // Back-to-back frames with different peaks.
    mr_mode = 0; c0 = cor_cnt; w0 = fd_cnt;
    fill(0); img[1*W+2] = 200; prepare_frame();
    fill(0); img[3*W+3] = 300; prepare_frame();
    drive(0, 2*W*H); wait_frames(w0 + 2);
    chk("t6_corners", cor_cnt - c0, 2);
    chk("t6_queues_empty", exp_win.size() + exp_cor.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
